log2_seq: RTL and testbench



---
 rtl/log2_pkg.sv | 19 +
 rtl/lead_one_det.sv | 22 ++
 rtl/qmult.sv | 32 +++
 rtl/log2_seq.sv | 160 ++++++++++++++++
 tb/tb_log2_seq.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/log2_pkg.sv
// Shared types and defaults for the sequential base-2 logarithm path.
package log2_pkg;

   localparam int N_DEF = 16;
   localparam int Q_DEF = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      NORM = 3'd1,
      MUL  = 3'd2,
      ACC  = 3'd3,
      DONE = 3'd4
   } state_t;

   function automatic int iter_width(input int q);
      return $clog2(q + 1);
   endfunction

endpackage

// File: rtl/lead_one_det.sv
// Priority encoder: index of the highest set bit of vec, plus an all-zero flag.
module lead_one_det #(
   parameter int W  = 15,
   parameter int PW = 4
) (
   input  logic [W-1:0]  vec,
   output logic [PW-1:0] pos,
   output logic          zero
);

   always_comb begin
      pos  = '0;
      zero = 1'b1;
      for (int i = 0; i < W; i++) begin
         if (vec[i]) begin
            pos  = PW'(i);
            zero = 1'b0;
         end
      end
   end

endmodule

// File: rtl/qmult.sv
// Combinational sign-magnitude Q-format multiplier; output forced to zero when not enabled.
module qmult #(
   parameter int N = 16,
   parameter int Q = 8
) (
   input  logic [N-1:0] multiplicand,
   input  logic [N-1:0] multiplier,
   input  logic         ena,
   output logic [N-1:0] o_result,
   output logic         ovr
);

   logic [2*N-3:0] prod;
   logic [2*N-3:0] prod_shift;
   logic [N-2:0]   mag;
   logic           sign;

   always_comb begin
      prod       = (2*N-2)'(multiplicand[N-2:0]) * (2*N-2)'(multiplier[N-2:0]);
      prod_shift = prod >> Q;
      mag        = prod_shift[N-2:0];
      // A zero product is always reported as +0.
      sign       = (multiplicand[N-1] ^ multiplier[N-1]) && (mag != '0);
      o_result   = '0;
      ovr        = 1'b0;
      if (ena) begin
         o_result = {sign, mag};
         ovr      = |prod_shift[2*N-3:N-1];
      end
   end

endmodule

// File: rtl/log2_seq.sv
// Sequential log2 of a sign-magnitude Q-format operand via normalise + repeated squaring.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// NORM  | leading-one search, exponent and mantissa normalisation, error screening
// MUL   | qmult squares m into sq
// ACC   | shift one fraction bit in from sq, renormalise m, count iterations
// DONE  | result presented until out_ready
module log2_seq
   import log2_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int Q = Q_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_x,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_log,
   output logic         out_err,
   output logic         busy
);

   localparam int PW = $clog2(N - 1);
   localparam int IW = iter_width(Q);
   localparam int EW = PW + 2;

   state_t state, state_nxt;

   logic [N-1:0]          x_reg, x_nxt;
   logic [N-1:0]          m, m_nxt;
   logic [N-1:0]          sq, sq_nxt;
   logic [Q-1:0]          frac, frac_nxt;
   logic [IW-1:0]         iter, iter_nxt;
   logic signed [EW-1:0]  e, e_nxt;
   logic                  err, err_nxt;

   logic [PW-1:0]         p;
   logic                  mag_zero;
   logic [N-1:0]          m_norm;
   logic signed [EW-1:0]  e_norm;
   logic [N-1:0]          mult_res;
   logic                  mult_ovr;

   logic signed [N:0]     l_val;
   logic [N:0]            l_abs;
   logic [N-2:0]          l_mag;

   lead_one_det #(.W(N - 1), .PW(PW)) u_lod (
      .vec  (x_reg[N-2:0]),
      .pos  (p),
      .zero (mag_zero)
   );

   qmult #(.N(N), .Q(Q)) u_qmult (
      .multiplicand (m),
      .multiplier   (m),
      .ena          (state == MUL),
      .o_result     (mult_res),
      .ovr          (mult_ovr)
   );

   // Bring the leading one to bit Q so that m lands in [1,2); low bits fall off.
   always_comb begin
      e_norm = EW'(int'(p) - Q);
      if (int'(p) >= Q) begin
         m_norm = {1'b0, x_reg[N-2:0]} >> (int'(p) - Q);
      end else begin
         m_norm = {1'b0, x_reg[N-2:0]} << (Q - int'(p));
      end
   end

   always_comb begin
      state_nxt = state;
      x_nxt     = x_reg;
      m_nxt     = m;
      sq_nxt    = sq;
      frac_nxt  = frac;
      iter_nxt  = iter;
      e_nxt     = e;
      err_nxt   = err;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               x_nxt     = in_x;
               err_nxt   = 1'b0;
               state_nxt = NORM;
            end
         end
         NORM: begin
            frac_nxt = '0;
            iter_nxt = '0;
            if (mag_zero || x_reg[N-1]) begin
               err_nxt   = 1'b1;
               e_nxt     = '0;
               state_nxt = DONE;
            end else begin
               e_nxt     = e_norm;
               m_nxt     = m_norm;
               state_nxt = MUL;
            end
         end
         MUL: begin
            sq_nxt    = mult_res;
            err_nxt   = err | mult_ovr;
            state_nxt = ACC;
         end
         ACC: begin
            // sq in [2,4) means this fraction bit is 1 and sq is halved back into [1,2).
            frac_nxt = Q'({frac, sq[Q+1]});
            m_nxt    = sq[Q+1] ? (sq >> 1) : sq;
            iter_nxt = iter + IW'(1);
            state_nxt = (iter_nxt == IW'(Q)) ? DONE : MUL;
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         x_reg <= '0;
         m     <= '0;
         sq    <= '0;
         frac  <= '0;
         iter  <= '0;
         e     <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         x_reg <= x_nxt;
         m     <= m_nxt;
         sq    <= sq_nxt;
         frac  <= frac_nxt;
         iter  <= iter_nxt;
         e     <= e_nxt;
         err   <= err_nxt;
      end
   end

   // Two's complement exponent.fraction, then folded into sign-magnitude.
   always_comb begin
      l_val = ((N+1)'(e) <<< Q) + $signed((N+1)'(frac));
      l_abs = l_val[N] ? (N+1)'(-l_val) : l_val;
      l_mag = l_abs[N-2:0];
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign out_err   = (state == DONE) && err;
   assign out_log   = ((state == DONE) && !err) ? {l_val[N] && (l_mag != '0), l_mag} : '0;

endmodule

// File: tb/tb_log2_seq.sv
// Self-checking bench for log2_seq: directed table, corner sequences and a random sweep.
module tb_log2_seq;

   localparam int N = 16;
   localparam int Q = 8;
   localparam int NORM_LAT = 2*Q + 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] in_x = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [N-1:0] out_log;
   logic         out_err;
   logic         busy;

   int n_cmp = 0;
   int n_bad = 0;

   log2_seq #(.N(N), .Q(Q)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_log   (out_log),
      .out_err   (out_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] x;
      logic [N-1:0] exp_log;
      logic         exp_err;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: real-number-style log2 by squaring, done on plain integers.
   function automatic void model(input logic [N-1:0] x, output logic [N-1:0] r, output logic er);
      longint mag, mm, sq, frac, lval, labs;
      int p, e;
      mag = longint'(x[N-2:0]);
      r = '0;
      er = 1'b1;
      if (x[N-1] || mag == 0) return;
      p = 0;
      for (int i = 0; i < N-1; i++) if ((mag >> i) & 1) p = i;
      e  = p - Q;
      mm = (p >= Q) ? (mag >> (p - Q)) : (mag << (Q - p));
      frac = 0;
      for (int k = 0; k < Q; k++) begin
         sq = (mm * mm) >> Q;
         if (sq >= (longint'(2) << Q)) begin
            frac = frac*2 + 1;
            mm = sq >> 1;
         end else begin
            frac = frac*2;
            mm = sq;
         end
      end
      lval = longint'(e) * (longint'(1) << Q) + frac;
      labs = (lval < 0) ? -lval : lval;
      r  = {lval < 0, labs[N-2:0]};
      er = 1'b0;
   endfunction

   // Offer x, then count edges from the accept edge until out_valid shows up.
   task automatic start_op(input logic [N-1:0] x);
      @(negedge clk);
      in_valid = 1'b1;
      in_x     = x;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic release_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic run_and_check(input string tag, input logic [N-1:0] x,
                                input logic [N-1:0] exp_log, input logic exp_err);
      int lat;
      start_op(x);
      wait_done(lat);
      if (exp_err) check({tag, "_lat_err_le2"}, {31'd0, (lat >= 1 && lat <= 2)}, 32'd1);
      else         check({tag, "_lat"}, lat, NORM_LAT);
      check({tag, "_log"}, {16'd0, out_log}, {16'd0, exp_log});
      check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
      release_out();
   endtask

   vec_t tbl[8];

   initial begin
      logic [N-1:0] mlog, x;
      logic         merr;
      int           lat;

      tbl[0] = '{16'h0100, 16'h0000, 1'b0};
      tbl[1] = '{16'h0200, 16'h0100, 1'b0};
      tbl[2] = '{16'h0080, 16'h8100, 1'b0};
      tbl[3] = '{16'h0001, 16'h8800, 1'b0};
      tbl[4] = '{16'h0180, 16'h0095, 1'b0};
      tbl[5] = '{16'h0300, 16'h0195, 1'b0};
      tbl[6] = '{16'h0000, 16'h0000, 1'b1};
      tbl[7] = '{16'h8100, 16'h0000, 1'b1};

      #2;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_out_log", {16'd0, out_log}, 32'd0);
      check("rst_out_err", {31'd0, out_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_and_check($sformatf("tbl%0d", i), tbl[i].x, tbl[i].exp_log, tbl[i].exp_err);
      end

      // Backpressure: DONE held for 10 cycles while a new operand is offered.
      start_op(16'h0300);
      wait_done(lat);
      check("bp_lat", lat, NORM_LAT);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_x     = 16'h0200;
         check("bp_out_log", {16'd0, out_log}, 32'h0195);
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_out_err", {31'd0, out_err}, 32'd0);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      release_out();
      check("bp_busy_after", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("bp_not_buffered", {31'd0, busy}, 32'd0);

      // Reset asserted during the fourth squaring.
      start_op(16'h0180);
      repeat (7) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("mid_rst_out_log", {16'd0, out_log}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_and_check("post_rst", 16'h0200, 16'h0100, 1'b0);

      // Random sweep against the reference, with occasional forced zero/negative operands.
      for (int i = 0; i < 40; i++) begin
         x = N'($urandom);
         if (i % 10 == 3) x = 16'h0000;
         if (i % 10 == 7) x[N-1] = 1'b1;
         model(x, mlog, merr);
         run_and_check($sformatf("rnd%0d_x%04h", i, x), x, mlog, merr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
